micro_seq_ctrl: RTL and testbench

MICRO_SEQ_CTRL -- requirements
Module: micro_seq_ctrl

---
 rtl/micro_seq_ctrl.sv | 111 +++++++++++
 tb/tb_micro_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/micro_seq_ctrl.sv
// Micro-op sequencer: expands a decoded instruction into up to eight micro-ops
// at consecutive micro-code addresses, with backpressure, flush and NOP handling.
module micro_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_pipeline,
  input  logic        dec_valid,
  input  logic [7:0]  uaddr_in,
  input  logic [2:0]  ucnt_in,
  input  logic [31:0] instr_in,
  output logic        dec_accept,
  input  logic        cu_ready,
  output logic        uop_valid,
  output logic [7:0]  uop_addr,
  output logic [31:0] uop_instr,
  output logic        uop_last,
  output logic        seq_err,
  output logic [15:0] uop_count
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  localparam logic [7:0] NOP_ADDR = 8'hFF;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [2:0]  rem_q, rem_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        consume;
  logic        last;
  logic        take;
  logic [7:0]  addr_inc;

  assign consume  = (state_q == ISSUE) & cu_ready;
  assign last     = (rem_q == 3'd0);
  assign addr_inc = addr_q + 8'd1;

  // Accept only when nothing will be held next cycle, so a new instruction
  // can follow the final micro-op with no bubble.
  assign dec_accept = ~rst & ~flush_pipeline &
                      ((state_q == IDLE) | ((state_q == ISSUE) & last & cu_ready));
  assign take       = dec_valid & dec_accept;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    // Consumption is counted even in a flush cycle.
    if (consume && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;

    if (flush_pipeline) begin
      state_d = IDLE;
      rem_d   = 3'd0;
    end else if (take && (uaddr_in != NOP_ADDR)) begin
      state_d = ISSUE;
      addr_d  = uaddr_in;
      instr_d = instr_in;
      rem_d   = ucnt_in;
    end else if (take) begin
      state_d = IDLE;
    end else if (consume) begin
      if (!last) begin
        if (addr_inc == NOP_ADDR) begin
          // Running into the NOP address aborts the sequence in place.
          state_d = IDLE;
          rem_d   = 3'd0;
          err_d   = 1'b1;
        end else begin
          addr_d = addr_inc;
          rem_d  = rem_q - 3'd1;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= NOP_ADDR;
      instr_q <= 32'd0;
      rem_q   <= 3'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign uop_valid = (state_q == ISSUE);
  assign uop_addr  = addr_q;
  assign uop_instr = instr_q;
  assign uop_last  = last;
  assign seq_err   = err_q;
  assign uop_count = cnt_q;

endmodule

// File: tb/tb_micro_seq_ctrl.sv
// Bench for micro_seq_ctrl: directed scenarios then random traffic, checked
// against a queue-of-pending-micro-ops reference model.
module tb_micro_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_pipeline;
  logic        dec_valid;
  logic [7:0]  uaddr_in;
  logic [2:0]  ucnt_in;
  logic [31:0] instr_in;
  logic        dec_accept;
  logic        cu_ready;
  logic        uop_valid;
  logic [7:0]  uop_addr;
  logic [31:0] uop_instr;
  logic        uop_last;
  logic        seq_err;
  logic [15:0] uop_count;

  int nchk  = 0;
  int nfail = 0;

  micro_seq_ctrl dut (
    .clk(clk), .rst(rst), .flush_pipeline(flush_pipeline), .dec_valid(dec_valid),
    .uaddr_in(uaddr_in), .ucnt_in(ucnt_in), .instr_in(instr_in),
    .dec_accept(dec_accept), .cu_ready(cu_ready), .uop_valid(uop_valid),
    .uop_addr(uop_addr), .uop_instr(uop_instr), .uop_last(uop_last),
    .seq_err(seq_err), .uop_count(uop_count)
  );

  always #5 clk = ~clk;

  // Reference model: the micro-ops still to be issued for the current instruction.
  typedef struct {
    logic [7:0]  a;
    logic [31:0] ins;
    bit          last;
    bit          err;   // consuming this one runs the address into 8'hFF
  } uop_t;

  uop_t        q[$];
  bit          m_err;
  logic [15:0] m_cnt;

  function automatic bit m_acc(input bit fl, input bit rdy);
    return !fl && (q.size() == 0 || (q[0].last && rdy));
  endfunction

  function automatic void m_reset();
    q.delete();
    m_err = 1'b0;
    m_cnt = 16'd0;
  endfunction

  function automatic void m_update(input bit fl, input bit dv, input logic [7:0] ua,
                                   input logic [2:0] uc, input logic [31:0] ins, input bit rdy);
    bit acc;
    uop_t u;
    acc = m_acc(fl, rdy);
    if (q.size() > 0 && rdy) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (q[0].err) m_err = 1'b1;
      void'(q.pop_front());
    end
    if (fl) q.delete();
    else if (acc && dv && ua != 8'hFF) begin
      for (int i = 0; i <= int'(uc); i++) begin
        if (int'(ua) + i == 255) begin
          q[q.size()-1].err = 1'b1;
          break;
        end
        u.a    = 8'(int'(ua) + i);
        u.ins  = ins;
        u.last = (i == int'(uc));
        u.err  = 1'b0;
        q.push_back(u);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " dec_accept"}, 32'(dec_accept), 32'd0);
    chk({tag, " uop_valid"},  32'(uop_valid),  32'd0);
    chk({tag, " uop_addr"},   32'(uop_addr),   32'hFF);
    chk({tag, " uop_instr"},  uop_instr,       32'd0);
    chk({tag, " uop_last"},   32'(uop_last),   32'd1);
    chk({tag, " seq_err"},    32'(seq_err),    32'd0);
    chk({tag, " uop_count"},  32'(uop_count),  32'd0);
  endtask

  // One cycle: drive at the falling edge, check, then advance model across the rising edge.
  task automatic step(input bit fl, input bit dv, input logic [7:0] ua, input logic [2:0] uc,
                      input logic [31:0] ins, input bit rdy);
    flush_pipeline = fl;
    dec_valid      = dv;
    uaddr_in       = ua;
    ucnt_in        = uc;
    instr_in       = ins;
    cu_ready       = rdy;
    #1;
    chk("dec_accept", 32'(dec_accept), 32'(m_acc(fl, rdy)));
    chk("uop_valid",  32'(uop_valid),  32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("uop_addr",  32'(uop_addr), 32'(q[0].a));
      chk("uop_instr", uop_instr,     q[0].ins);
      chk("uop_last",  32'(uop_last), 32'(q[0].last));
    end
    chk("seq_err",   32'(seq_err),   32'(m_err));
    chk("uop_count", 32'(uop_count), 32'(m_cnt));
    @(posedge clk);
    m_update(fl, dv, ua, uc, ins, rdy);
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'd0, rdy);
  endtask

  initial begin
    rst = 1'b1;
    flush_pipeline = 1'b0; dec_valid = 1'b0; uaddr_in = 8'h00;
    ucnt_in = 3'd0; instr_in = 32'd0; cu_ready = 1'b0;
    m_reset();
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single micro-op
    step(1'b0, 1'b1, 8'h05, 3'd0, 32'hA000_0005, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Multi micro-op 3A..3E
    step(1'b0, 1'b1, 8'h3A, 3'd4, 32'hB000_003A, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h50, 3'd0, 32'h5, 1'b1);
    idle(1'b1);

    // Backpressure
    step(1'b0, 1'b1, 8'h05, 3'd0, 32'hC000_0005, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h60, 3'd1, 32'h6, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // NOP then back-to-back
    step(1'b0, 1'b1, 8'hFF, 3'd3, 32'hDEAD_BEEF, 1'b1);
    step(1'b0, 1'b1, 8'h07, 3'd2, 32'hD000_0007, 1'b1);
    idle(1'b1);
    idle(1'b1);
    step(1'b0, 1'b1, 8'h20, 3'd0, 32'hD000_0020, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush while 0B with remaining=1
    step(1'b0, 1'b1, 8'h0A, 3'd2, 32'hE000_000A, 1'b1);
    idle(1'b1);
    step(1'b1, 1'b1, 8'h30, 3'd0, 32'hE000_0030, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Address wrap into 8'hFF
    step(1'b0, 1'b1, 8'hFD, 3'd3, 32'hF000_00FD, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset mid-sequence
    step(1'b0, 1'b1, 8'h40, 3'd5, 32'h4040_4040, 1'b1);
    idle(1'b0);
    flush_pipeline = 1'b0; dec_valid = 1'b1; uaddr_in = 8'h41; cu_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    chk_reset_vals("rst_held");
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    idle(1'b1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [7:0] ua;
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0)      ua = 8'hFF;
      else if (sel == 1) ua = 8'hF8 + 8'($urandom_range(0, 6));
      else               ua = 8'($urandom);
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, ua,
           3'($urandom), $urandom, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
